// File: rtl/rd_control_fwft.sv
// rd_control_fwft: read-side pointer/flag controller of an async FIFO with a
// first-word-fall-through output register and a valid/ready handshake.
// The write Gray pointer arrives already synchronised into rclk; the RAM read
// is combinational on raddr.
// Optional feature: define RD_LEVEL_EN to build the registered rlevel fill count
// (otherwise rlevel is tied to zero and no gray-to-binary logic is built).
module rd_control_fwft #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [ADDRWIDTH:0]   wptr_rclk,
  output logic [ADDRWIDTH-1:0] raddr,
  input  logic [DATAWIDTH-1:0] rdata_mem,
  output logic [ADDRWIDTH:0]   rptr,
  output logic                 rempty,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [ADDRWIDTH:0]   rlevel
);

  localparam int PW = ADDRWIDTH + 1;

  logic [PW-1:0]        rbin_reg;
  logic [PW-1:0]        rbin_next;
  logic [PW-1:0]        rptr_reg;
  logic [PW-1:0]        rptr_next;
  logic                 rempty_reg;
  logic                 rempty_next;
  logic                 rpop;
  logic [DATAWIDTH-1:0] dout_reg;
  logic                 dout_valid_reg;

  // A RAM word is popped when one is available and the output register is
  // either empty or being emptied this cycle (so streaming has no bubble).
  assign rpop        = ~rempty_reg & (~dout_valid_reg | dout_ready);
  assign rbin_next   = rbin_reg + {{ADDRWIDTH{1'b0}}, rpop};
  assign rptr_next   = (rbin_next >> 1) ^ rbin_next;
  // Comparing against the synchronised (possibly stale) write pointer can only
  // keep rempty asserted longer, never release it early.
  assign rempty_next = (rptr_next == wptr_rclk);

  // Binary/Gray read pointer and empty flag, all registered.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_reg   <= '0;
      rptr_reg   <= '0;
      rempty_reg <= 1'b1;
    end else begin
      rbin_reg   <= rbin_next;
      rptr_reg   <= rptr_next;
      rempty_reg <= rempty_next;
    end
  end

  // FWFT output register: load on pop, clear valid on a plain transfer, else hold.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else if (rpop) begin
      dout_reg       <= rdata_mem;
      dout_valid_reg <= 1'b1;
    end else if (dout_valid_reg && dout_ready) begin
      dout_valid_reg <= 1'b0;
    end
  end

`ifdef RD_LEVEL_EN
  logic [PW-1:0] wbin;
  logic [PW-1:0] rlevel_reg;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
    assign wbin[gi] = ^(wptr_rclk >> gi);
  end

  // Fill level of the RAM as seen after this cycle's pop (modular difference).
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rlevel_reg <= '0;
    end else begin
      rlevel_reg <= wbin - rbin_next;
    end
  end

  assign rlevel = rlevel_reg;
`else
  assign rlevel = '0;
`endif

  assign raddr      = rbin_reg[ADDRWIDTH-1:0];
  assign rptr       = rptr_reg;
  assign rempty     = rempty_reg;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;

endmodule

// File: tb/tb_rd_control_fwft.sv
// tb_rd_control_fwft: directed and randomized checks of rd_control_fwft against
// a word-count/queue model of the FIFO read side.
module tb_rd_control_fwft;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [PW-1:0] wptr_rclk;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata_mem;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [PW-1:0] rlevel;

  logic [DW-1:0] ram [16];
  assign rdata_mem = ram[raddr];

  always #5 rclk = ~rclk;

  rd_control_fwft #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .wptr_rclk  (wptr_rclk),
    .raddr      (raddr),
    .rdata_mem  (rdata_mem),
    .rptr       (rptr),
    .rempty     (rempty),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .rlevel     (rlevel)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: counts of words written / read from RAM, queue of unread words.
  int            w_total;
  int            r_total;
  logic [DW-1:0] q [$];
  bit            m_valid;
  bit            m_rempty;
  logic [DW-1:0] m_dout;
  int            dut_xfers;

  function automatic logic [PW-1:0] gray(input int n);
    logic [PW-1:0] b;
    b = n[PW-1:0];
    return (b >> 1) ^ b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int lvl;
`ifdef RD_LEVEL_EN
    lvl = w_total - r_total;
`else
    lvl = 0;
`endif
    chk({ph, ".rempty"},     32'(rempty),     32'(m_rempty));
    chk({ph, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
    chk({ph, ".dout"},       32'(dout),       32'(m_dout));
    chk({ph, ".rptr"},       32'(rptr),       32'(gray(r_total)));
    chk({ph, ".raddr"},      32'(raddr),      32'(r_total % 16));
    chk({ph, ".rlevel"},     32'(rlevel),     32'(lvl));
  endtask

  task automatic model_reset();
    w_total  = 0;
    r_total  = 0;
    q.delete();
    m_valid  = 1'b0;
    m_rempty = 1'b1;
    m_dout   = '0;
  endtask

  // One rclk cycle: drive inputs at negedge, advance the model, check after posedge.
  task automatic step(input bit ready, input bit wr, input bit fixed = 1'b0,
                      input logic [DW-1:0] d = '0);
    logic [DW-1:0] wd;
    bit            pop;
    @(negedge rclk);
    if (wr && (w_total - r_total) < 16) begin
      wd = fixed ? d : DW'($urandom);
      ram[w_total % 16] = wd;
      q.push_back(wd);
      w_total++;
      wptr_rclk = gray(w_total);
    end
    dout_ready = ready;
    if (dout_valid && ready) dut_xfers++;
    pop = !m_rempty && (!m_valid || ready);
    if (pop) begin
      m_dout  = q.pop_front();
      m_valid = 1'b1;
      r_total++;
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    m_rempty = (r_total == w_total);
    @(posedge rclk);
    #1;
    check_all("step");
  endtask

  // Asynchronous reset applied mid-cycle; effects must be visible immediately.
  task automatic do_reset();
    @(negedge rclk);
    #2;
    rrst      = 1'b1;
    wptr_rclk = 5'b00011;
    #1;
    chk("rst.dout_valid", 32'(dout_valid), 32'd0);
    chk("rst.rptr",       32'(rptr),       32'd0);
    chk("rst.rempty",     32'(rempty),     32'd1);
    chk("rst.raddr",      32'(raddr),      32'd0);
    chk("rst.rlevel",     32'(rlevel),     32'd0);
    chk("rst.dout",       32'(dout),       32'd0);
    wptr_rclk = '0;
    model_reset();
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] word0;
    int            guard;

    rrst       = 1'b1;
    dout_ready = 1'b0;
    wptr_rclk  = 5'b00011;
    dut_xfers  = 0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    model_reset();

    // Reset state
    do_reset();
    step(1'b0, 1'b0);

    // Single word: rempty drops one cycle after the write pointer, data one later
    step(1'b1, 1'b1, 1'b1, 8'hA5);
    chk("single.rempty_n1", 32'(rempty), 32'd0);
    step(1'b1, 1'b0);
    chk("single.dout",   32'(dout),       32'hA5);
    chk("single.valid",  32'(dout_valid), 32'd1);
    chk("single.rptr",   32'(rptr),       32'b00001);
    chk("single.rempty", 32'(rempty),     32'd1);
    step(1'b1, 1'b0);
    chk("single.drained", 32'(dout_valid), 32'd0);

    // Back-pressure: three words held off for five cycles
    do_reset();
    word0 = 8'h3C;
    step(1'b0, 1'b1, 1'b1, word0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("bp.dout_held", 32'(dout),       32'(word0));
    chk("bp.one_read",  32'(rptr),       32'b00001);
`ifdef RD_LEVEL_EN
    chk("bp.rlevel",    32'(rlevel),     32'd2);
`endif
    dut_xfers = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("bp.xfers", 32'(dut_xfers), 32'd3);

    // Full drain: sixteen words, then back-to-back output
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
    chk("drain.wptr_full", 32'(wptr_rclk), 32'b11000);
    dut_xfers = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    chk("drain.xfers", 32'(dut_xfers), 32'd16);
    chk("drain.rptr",  32'(rptr),      32'b11000);

    // Wrap: advance the read pointer to 31, then across to 0
    guard = 0;
    while (r_total < 31 && guard < 200) begin
      step(1'b1, (w_total < 32));
      guard++;
    end
    chk("wrap.reach31", 32'(r_total), 32'd31);
    chk("wrap.rptr31",  32'(rptr),    32'b10000);
    chk("wrap.raddr15", 32'(raddr),   32'd15);
    guard = 0;
    while (r_total < 32 && guard < 50) begin
      step(1'b1, 1'b1);
      guard++;
    end
    chk("wrap.reach32", 32'(r_total), 32'd32);
    chk("wrap.rptr0",   32'(rptr),    32'b00000);
    chk("wrap.raddr0",  32'(raddr),   32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);

    // Reset mid-stream with a word held in the output register
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("midrst.pre_valid", 32'(dout_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
